// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: command encodings, sequencer states and RF pair address for rf_op_sequencer
package rf_seq_pkg;
  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_EXEC  = 2'd3
  } op_e;
  typedef enum logic [2:0] {
    IDLE,
    LD_REQ,
    LD_WAIT,
    LD_WB,
    ST,
    EX_START,
    EX_WAIT,
    EX_WB
  } state_e;
  localparam logic [2:0] RF_PAIR_ADDR = 3'b100;
endpackage

// File: rtl/rf_seq_timeout.sv
// rf_seq_timeout: ALU wait counter that flags the last allowed wait cycle
module rf_seq_timeout #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  end
  assign o_expired = i_en && r_cnt == LAST;
endmodule

// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: command sequencer driving the operand RF write port, memory and ALU
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int MEM_LAT     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        cmd_reg,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [511:0]      mem_wdata,
  input  logic [511:0]      mem_rdata,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [1023:0]     alu_result,
  output logic              rf_write,
  output logic [2:0]        rf_write_address,
  output logic [1023:0]     rf_write_data,
  input  logic [511:0]      rf_a1,
  input  logic [511:0]      rf_a2,
  input  logic [511:0]      rf_a3,
  input  logic [511:0]      rf_a4,
  output logic              busy,
  output logic              err
);
  localparam int LW = $clog2(MEM_LAT + 1);
  localparam logic [LW-1:0] LD_LAST = LW'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);
  state_e            r_state;
  state_e            w_next;
  logic [1:0]        r_reg;
  logic [ADDR_W-1:0] r_addr;
  logic [LW-1:0]     r_lcnt;
  logic              r_err;
  logic              w_run;
  logic              w_acc;
  logic              w_ld_wb;
  logic              w_ex_wb;
  logic              w_tmo;
  logic              w_expired;
  logic              w_tmo_clr;
  logic              w_tmo_en;
  logic [511:0]      w_st_data;

  assign w_run     = !rst;
  assign w_acc     = cmd_ready && cmd_valid;
  assign w_ld_wb   = r_state == LD_WB;
  assign w_ex_wb   = r_state == EX_WAIT && alu_done;
  assign w_tmo     = r_state == EX_WAIT && !alu_done && w_expired;
  assign w_tmo_clr = r_state == EX_START;
  assign w_tmo_en  = r_state == EX_WAIT;

  rf_seq_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_tmo_clr),
    .i_en      (w_tmo_en),
    .o_expired (w_expired)
  );

  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_acc)
      w_next = cmd_op == OP_LOAD ? LD_REQ : cmd_op == OP_STORE ? ST : cmd_op == OP_EXEC ? EX_START : IDLE;
    else if (r_state == LD_REQ) w_next = MEM_LAT == 1 ? LD_WB : LD_WAIT;
    else if (r_state == LD_WAIT && r_lcnt == LD_LAST) w_next = LD_WB;
    else if (r_state == EX_START) w_next = EX_WAIT;
    else if (w_ex_wb || w_tmo || r_state == LD_WB || r_state == ST || r_state == EX_WB) w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_reg   <= '0;
      r_addr  <= '0;
      r_lcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_lcnt  <= r_state == LD_WAIT ? r_lcnt + 1'b1 : '0;
      if (w_acc) begin
        r_reg  <= cmd_reg;
        r_addr <= cmd_addr;
      end
      if (w_tmo) r_err <= 1'b1;
    end
  end

  assign w_st_data = r_reg == 2'd0 ? rf_a1 : r_reg == 2'd1 ? rf_a2 : r_reg == 2'd2 ? rf_a3 : rf_a4;

  assign cmd_ready = w_run && r_state == IDLE;
  assign busy      = !cmd_ready;
  assign mem_en    = w_run && (r_state == LD_REQ || r_state == ST);
  assign mem_we    = w_run && r_state == ST;
  assign mem_addr  = mem_en ? r_addr : '0;
  assign mem_wdata = mem_we ? w_st_data : '0;
  assign alu_start = w_run && r_state == EX_START;
  assign rf_write  = w_run && w_ld_wb;
  // Address bit2 forces a pair write in the RF, so address and data stay zero outside writeback
  assign rf_write_address = !w_run ? '0 : w_ld_wb ? {1'b0, r_reg} : w_ex_wb ? RF_PAIR_ADDR : '0;
  assign rf_write_data    = !w_run ? '0 : w_ld_wb ? {512'b0, mem_rdata} : w_ex_wb ? alu_result : '0;
  assign err = r_err;
endmodule

// File: tb/tb_rf_op_sequencer.sv
// tb_rf_op_sequencer: directed and random commands checked against an abstract RF/memory model
module tb_rf_op_sequencer;
  localparam int ADDR_W = 16;
  localparam int MEM_LAT = 2;
  localparam int TMO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic env_init = 1'b1;
  logic cmd_valid = 1'b0;
  logic alu_done = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [1:0] cmd_reg = '0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [1023:0] alu_result = '0;
  logic cmd_ready, mem_en, mem_we, alu_start, rf_write, busy, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [511:0] mem_wdata, mem_rdata;
  logic [1023:0] rf_write_data;
  logic [2:0] rf_write_address;
  logic [511:0] e_rf [4];
  logic [511:0] e_mem [64];
  logic [511:0] pipe [MEM_LAT];
  logic [511:0] m_rf [4];
  logic [511:0] m_mem [64];
  logic m_err = 1'b0;
  int n_chk = 0, n_fail = 0;
  int n_rfw = 0, n_pair = 0, n_mem = 0, n_alu = 0, n_acc = 0, n_spur = 0;

  always #5 clk = ~clk;

  rf_op_sequencer #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_reg(cmd_reg), .cmd_addr(cmd_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .alu_start(alu_start), .alu_done(alu_done),
    .alu_result(alu_result), .rf_write(rf_write), .rf_write_address(rf_write_address),
    .rf_write_data(rf_write_data), .rf_a1(e_rf[0]), .rf_a2(e_rf[1]), .rf_a3(e_rf[2]), .rf_a4(e_rf[3]),
    .busy(busy), .err(err)
  );

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [511:0] init_word(input int i);
    return i == 16 ? 512'hABCD : i == 18 ? 512'h55 : {16{32'(i) * 32'h9E3779B9}};
  endfunction

  assign mem_rdata = pipe[MEM_LAT-1];

  // Memory and register-file emulation plus activity counters
  always @(posedge clk) begin
    if (env_init) begin
      for (int i = 0; i < 64; i++) e_mem[i] <= init_word(i);
      for (int i = 0; i < 4; i++) e_rf[i] <= '0;
    end else begin
      if (mem_en && mem_we) e_mem[mem_addr[5:0]] <= mem_wdata;
      if (rf_write_address[2]) begin
        e_rf[3] <= rf_write_data[1023:512];
        e_rf[2] <= rf_write_data[511:0];
      end else if (rf_write) e_rf[rf_write_address[1:0]] <= rf_write_data[511:0];
    end
    pipe[0] <= (mem_en && !mem_we) ? e_mem[mem_addr[5:0]] : rnd512();
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    n_rfw  <= n_rfw + (rf_write ? 1 : 0);
    n_pair <= n_pair + (rf_write_address[2] ? 1 : 0);
    n_mem  <= n_mem + (mem_en ? 1 : 0);
    n_alu  <= n_alu + (alu_start ? 1 : 0);
    n_acc  <= n_acc + ((cmd_valid && cmd_ready) ? 1 : 0);
    if ((!rf_write && !rf_write_address[2] && (rf_write_address != 3'b0 || rf_write_data != '0)) ||
        (cmd_ready && (mem_en || alu_start || rf_write || rf_write_address != 3'b0)))
      n_spur <= n_spur + 1;
  end

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h (low 128 bits)", tag, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] r, input logic [ADDR_W-1:0] a);
    chk("ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_reg = r;
    cmd_addr = a;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom);
    cmd_reg = 2'($urandom);
    cmd_addr = 16'($urandom);
  endtask

  task automatic do_load(input logic [1:0] r, input logic [ADDR_W-1:0] a);
    logic [511:0] exp;
    int b;
    exp = m_mem[a[5:0]];
    b = n_rfw;
    issue(2'd1, r, a);
    chk("ld_en", {mem_en, mem_we}, 2'b10);
    chk("ld_addr", mem_addr, a);
    for (int i = 1; i < MEM_LAT; i++) begin
      @(negedge clk);
      chk("ld_wait", {mem_en, rf_write, busy}, 3'b001);
    end
    @(negedge clk);
    chk("ld_wr", rf_write, 1'b1);
    chk("ld_wa", rf_write_address, {1'b0, r});
    chk("ld_wd", rf_write_data, {512'b0, exp});
    m_rf[r] = exp;
    @(negedge clk);
    chk("ld_done", {cmd_ready, busy}, 2'b10);
    chk("ld_rf", e_rf[r], m_rf[r]);
    chk("ld_cnt", n_rfw - b, 1);
    chk("ld_err", err, m_err);
  endtask

  task automatic do_store(input logic [1:0] r, input logic [ADDR_W-1:0] a);
    issue(2'd2, r, a);
    chk("st_en", {mem_en, mem_we}, 2'b11);
    chk("st_addr", mem_addr, a);
    chk("st_wd", mem_wdata, m_rf[r]);
    m_mem[a[5:0]] = m_rf[r];
    @(negedge clk);
    chk("st_done", {cmd_ready, mem_en}, 2'b10);
    chk("st_mem", e_mem[a[5:0]], m_mem[a[5:0]]);
  endtask

  // dly = cycles from alu_start to alu_done; 0 means the ALU never answers
  task automatic do_exec(input int dly, input logic [1023:0] res);
    int b;
    bit fin;
    b = n_pair;
    fin = 1'b0;
    issue(2'd3, 2'($urandom), 16'($urandom));
    chk("ex_start", {alu_start, rf_write_address}, 4'b1000);
    for (int k = 1; k <= TMO + 1 && !fin; k++) begin
      @(negedge clk);
      if (k == dly) begin
        alu_done = 1'b1;
        alu_result = res;
        #1;
        chk("ex_wa", rf_write_address, 3'b100);
        chk("ex_wd", rf_write_data, res);
        chk("ex_rfw", rf_write, 1'b0);
        @(negedge clk);
        alu_done = 1'b0;
        alu_result = {rnd512(), rnd512()};
        m_rf[2] = res[511:0];
        m_rf[3] = res[1023:512];
        fin = 1'b1;
      end else if (k == TMO + 1) begin
        chk("ex_err", err, 1'b1);
        m_err = 1'b1;
      end else chk("ex_wait", {alu_start, rf_write_address, cmd_ready, err}, {5'b0, m_err});
    end
    chk("ex_idle", cmd_ready, 1'b1);
    chk("ex_pair", n_pair - b, fin ? 1 : 0);
    chk("ex_a3", e_rf[2], m_rf[2]);
    chk("ex_a4", e_rf[3], m_rf[3]);
  endtask

  initial begin
    int b_acc, b_act, op, dly;
    logic [1:0] r;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 64; i++) m_mem[i] = init_word(i);
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    alu_result = {rnd512(), rnd512()};
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_strb", {mem_en, mem_we, alu_start, rf_write, rf_write_address, err}, '0);
    env_init = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_out", {cmd_ready, busy, mem_en, alu_start, rf_write, err, rf_write_address}, 9'b100000000);
    chk("rst_wd", rf_write_data, '0);
    @(negedge clk);
    do_load(2'd2, 16'h0010);
    do_load(2'd1, 16'h0012);
    do_store(2'd1, 16'h0013);
    do_exec(5, (1024'd1 << 512) | 1024'd2);
    do_exec(TMO, {rnd512(), rnd512()});
    chk("no_err", err, 1'b0);
    do_exec(0, '0);
    do_load(2'd0, 16'h0013);
    b_acc = n_acc;
    b_act = n_mem + n_alu + n_rfw + n_pair;
    cmd_valid = 1'b1;
    cmd_op = 2'd0;
    repeat (4) begin
      chk("nop_ready", cmd_ready, 1'b1);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("nop_acc", n_acc - b_acc, 4);
    chk("nop_act", n_mem + n_alu + n_rfw + n_pair - b_act, 0);
    b_act = n_rfw + n_pair;
    issue(2'd1, 2'd3, 16'h0011);
    chk("rm_req", mem_en, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rm_strb", {mem_en, alu_start, rf_write, rf_write_address, cmd_ready}, '0);
    rst = 1'b0;
    #1;
    chk("rm_clr", {cmd_ready, err}, 2'b10);
    m_err = 1'b0;
    alu_done = 1'b1;
    #1;
    chk("rm_late", {rf_write_address, rf_write}, '0);
    chk("rm_late_d", rf_write_data, '0);
    @(negedge clk);
    alu_done = 1'b0;
    chk("rm_idle", cmd_ready, 1'b1);
    chk("rm_nowr", n_rfw + n_pair - b_act, 0);
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 3);
      r = 2'($urandom);
      a = 16'h0010 + 16'($urandom_range(0, 7));
      case (op)
        0: begin
          cmd_valid = 1'b1;
          cmd_op = 2'd0;
          @(negedge clk);
          cmd_valid = 1'b0;
          chk("r_nop", cmd_ready, 1'b1);
        end
        1: do_load(r, a);
        2: do_store(r, a);
        default: begin
          dly = $urandom_range(0, TMO);
          do_exec(dly, {rnd512(), rnd512()});
        end
      endcase
      for (int i = 0; i < 4; i++) chk("r_rf", e_rf[i], m_rf[i]);
      chk("r_err", err, m_err);
    end
    for (int i = 0; i < 64; i++) chk("mem", e_mem[i], m_mem[i]);
    chk("spurious", n_spur, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
